// File: rtl/pwm_regs_pkg.sv
// pwm_regs_pkg
// Shared constants for the PWM timer register file. Each of the three channels
// owns four consecutive 16-bit words: ctrl, period, divisor and duty cycle.
// reg_index() gives the flat register index of a word within a channel.
package pwm_regs_pkg;

  localparam int REG_CTRL    = 0;
  localparam int REG_PERIOD  = 1;
  localparam int REG_DIVISOR = 2;
  localparam int REG_DC      = 3;

  localparam int REGS_PER_CH = 4;
  localparam int NUM_CH      = 3;

  localparam int MEM_WIDTH_DEF = 16;
  localparam int MEM_DEPTH_DEF = REGS_PER_CH * NUM_CH;
  localparam int ADR_WIDTH_DEF = 16;

  function automatic int reg_index(input int ch, input int word);
    return ch * REGS_PER_CH + word;
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// wb_regfile
// mem_depth x mem_width register array with synchronous active-high reset,
// one write port, one registered read port and a flat image of all words.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (clears array and read data)
//   we_i       write enable, qualified by the caller
//   re_i       read enable, qualified by the caller
//   idx_i      register index for both ports
//   wdata_i    write data
//   rdata_o    registered read data, holds when re_i is low
//   regs_o     flat image, word k at [k*mem_width +: mem_width]
module wb_regfile
  import pwm_regs_pkg::*;
#(
  parameter int mem_width = MEM_WIDTH_DEF,
  parameter int mem_depth = MEM_DEPTH_DEF,
  parameter int idx_width = $clog2(mem_depth)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [idx_width-1:0]           idx_i,
  input  logic [mem_width-1:0]           wdata_i,
  output logic [mem_width-1:0]           rdata_o,
  output logic [mem_width*mem_depth-1:0] regs_o
);

  logic [mem_width-1:0] mem_q [mem_depth];
  logic [mem_width-1:0] rdata_q;

  // The read samples the array before any same-edge write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < mem_depth; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[idx_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[idx_i];
    end
  end

  for (genvar k = 0; k < mem_depth; k++) begin : g_flat
    assign regs_o[k*mem_width +: mem_width] = mem_q[k];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_slave.sv
// wb_slave
// Wishbone classic slave in front of the PWM timer register file. Every clock
// with cyc&stb and an in-range address is one transfer, acknowledged on the
// following cycle with no wait states. The PWM core sees all registers at once
// through o_regs.
// Optional feature macro: WB_SLAVE_ERR_EN adds o_wb_err, which flags requests
// to out-of-range addresses one cycle later instead of leaving them unanswered.
// Ports:
//   i_wb_clk   clock, rising edge
//   i_wb_rst   synchronous active-high reset
//   i_wb_cyc   bus cycle valid
//   i_wb_stb   transfer strobe
//   i_wb_we    1 = write, 0 = read
//   i_wb_adr   word address
//   i_wb_data  write data
//   o_wb_ack   registered acknowledge
//   o_wb_data  registered read data
//   o_regs     flat register image, reg k at [k*mem_width +: mem_width]
//   o_wb_err   registered error (WB_SLAVE_ERR_EN only)
module wb_slave
  import pwm_regs_pkg::*;
#(
  parameter int mem_width = MEM_WIDTH_DEF,
  parameter int mem_depth = MEM_DEPTH_DEF,
  parameter int adr_width = ADR_WIDTH_DEF
) (
  input  logic                           i_wb_clk,
  input  logic                           i_wb_rst,
  input  logic                           i_wb_cyc,
  input  logic                           i_wb_stb,
  input  logic                           i_wb_we,
  input  logic [adr_width-1:0]           i_wb_adr,
  input  logic [mem_width-1:0]           i_wb_data,
  output logic                           o_wb_ack,
  output logic [mem_width-1:0]           o_wb_data,
  output logic [mem_width*mem_depth-1:0] o_regs
`ifdef WB_SLAVE_ERR_EN
  ,
  output logic                           o_wb_err
`endif
);

  localparam int IDX_W = $clog2(mem_depth);

  logic req;
  logic in_range;
  logic valid;
  logic ack_d, ack_q;

  // Full-width compare so high address bits never alias onto the array.
  assign req      = i_wb_cyc & i_wb_stb;
  assign in_range = i_wb_adr < adr_width'(mem_depth);
  assign valid    = req & in_range;
  assign ack_d    = valid;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) ack_q <= 1'b0;
    else          ack_q <= ack_d;
  end

  assign o_wb_ack = ack_q;

`ifdef WB_SLAVE_ERR_EN
  logic err_d, err_q;

  assign err_d = req & ~in_range;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_wb_err = err_q;
`endif

  wb_regfile #(
    .mem_width (mem_width),
    .mem_depth (mem_depth),
    .idx_width (IDX_W)
  ) u_regfile (
    .clk_i   (i_wb_clk),
    .rst_i   (i_wb_rst),
    .we_i    (valid & i_wb_we),
    .re_i    (valid & ~i_wb_we),
    .idx_i   (i_wb_adr[IDX_W-1:0]),
    .wdata_i (i_wb_data),
    .rdata_o (o_wb_data),
    .regs_o  (o_regs)
  );

endmodule

// File: tb/tb_wb_slave.sv
module tb_wb_slave;

  localparam int W = 16;
  localparam int D = 12;
  localparam int A = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cyc, stb, we;
  logic [A-1:0]   adr;
  logic [W-1:0]   wdata;
  logic           ack;
  logic [W-1:0]   rdata;
  logic [W*D-1:0] regs;

  logic [W-1:0]   exp_mem [D];
  logic [W-1:0]   sweep   [D];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_slave dut (
    .i_wb_clk  (clk),
    .i_wb_rst  (rst),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .i_wb_we   (we),
    .i_wb_adr  (adr),
    .i_wb_data (wdata),
    .o_wb_ack  (ack),
    .o_wb_data (rdata),
    .o_regs    (regs)
  );

  function automatic logic [W*D-1:0] exp_image();
    logic [W*D-1:0] img;
    for (int k = 0; k < D; k++) img[k*W +: W] = exp_mem[k];
    return img;
  endfunction

  task automatic check(input string tag, input logic [W*D-1:0] obs,
                       input logic [W*D-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    sweep[0] = 16'h1234; sweep[1] = 16'hBEEF; sweep[2]  = 16'h0F0F; sweep[3]  = 16'h8001;
    sweep[4] = 16'h7FFE; sweep[5] = 16'h5A5A; sweep[6]  = 16'hC0DE; sweep[7]  = 16'h0001;
    sweep[8] = 16'hFFFF; sweep[9] = 16'h2468; sweep[10] = 16'h1357; sweep[11] = 16'hABCD;
    for (int k = 0; k < D; k++) exp_mem[k] = '0;

    // 1 reset
    rst = 1'b1; idle(); adr = '0; wdata = '0;
    step();
    rst = 1'b0;
    check("reset_ack",  ack,   0);
    check("reset_data", rdata, 0);
    check("reset_regs", regs,  exp_image());

    // 2 back-to-back write sweep
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    for (int k = 0; k < D; k++) begin
      adr = A'(k); wdata = sweep[k];
      step();
      exp_mem[k] = sweep[k];
      check($sformatf("sweep_ack_%0d", k), ack, 1);
      check($sformatf("sweep_reg_%0d", k), regs[k*W +: W], sweep[k]);
    end
    idle();
    step();
    check("sweep_ack_drops", ack,   0);
    check("sweep_image",     regs,  exp_image());
    check("sweep_data_hold", rdata, 0);

    // 3 write then read
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd5; wdata = 16'hA5C3;
    step();
    exp_mem[5] = 16'hA5C3;
    we = 1'b0;
    step();
    check("rd5_data", rdata, 16'hA5C3);
    check("rd5_ack",  ack,   1);
    adr = 16'd11;
    step();
    check("rd11_data", rdata, 16'hABCD);
    check("rd11_ack",  ack,   1);
    idle();
    step();
    check("rd_idle_ack",  ack,   0);
    check("rd_idle_hold", rdata, 16'hABCD);

    // 4 out of range, including an address that would alias onto reg 5
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd12; wdata = 16'h1111;
    step();
    check("oor12_ack", ack, 0);
    adr = 16'd17; wdata = 16'h2222;
    step();
    check("oor17_ack", ack, 0);
    adr = 16'h1005; wdata = 16'h3333;
    step();
    check("oor_alias_ack", ack, 0);
    we = 1'b0; adr = 16'hFFFF;
    step();
    check("oor_rd_ack",  ack,   0);
    check("oor_rd_hold", rdata, 16'hABCD);
    check("oor_image",   regs,  exp_image());

    // 5 strobe gating
    cyc = 1'b1; stb = 1'b0; we = 1'b1; adr = 16'd2; wdata = 16'hFFFF;
    step();
    check("nostb_ack", ack, 0);
    check("nostb_reg2", regs[2*W +: W], 16'h0F0F);
    cyc = 1'b0; stb = 1'b1;
    step();
    check("nocyc_ack",   ack,  0);
    check("nocyc_image", regs, exp_image());

    // 6 reset mid-burst
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd4; wdata = 16'h4444;
    step();
    exp_mem[4] = 16'h4444;
    check("burst_ack", ack, 1);
    rst = 1'b1; adr = 16'd3; wdata = 16'h3333;
    step();
    rst = 1'b0; idle();
    for (int k = 0; k < D; k++) exp_mem[k] = '0;
    check("rstmid_reg3",  regs[3*W +: W], 0);
    check("rstmid_ack",   ack,   0);
    check("rstmid_data",  rdata, 0);
    check("rstmid_image", regs,  exp_image());
    step();
    check("post_rst_ack", ack, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
